// File: rtl/scan_pkg.sv
// Shared types and sizing for the scan-chain loader: FSM state encoding,
// default geometry and counter-width helpers.
package scan_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MEM_SIZE_DEF   = 32;
  localparam int CHAIN_LEN      = DATA_WIDTH_DEF * MEM_SIZE_DEF;
  localparam int BIT_CNT_W      = $clog2(DATA_WIDTH_DEF);
  localparam int BYTE_CNT_W     = $clog2(MEM_SIZE_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_capture.sv
// Readback deserialiser: gathers chain output bits MSB first and pulses
// rd_valid for one cycle with each completed byte.
module scan_capture
  import scan_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  sample_en,
  input  logic                  sample_bit,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int BW = cnt_w(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (clr) begin
      cap_d = '0;
      cnt_d = '0;
    end else if (sample_en) begin
      cap_d = {cap_q[DATA_WIDTH-2:0], sample_bit};
      if (cnt_q == LAST_BIT) begin
        cnt_d      = '0;
        rd_valid_d = 1'b1;
        rd_data_d  = {cap_q[DATA_WIDTH-2:0], sample_bit};
      end else begin
        cnt_d = cnt_q + BIT_ONE;
      end
    end else begin
      cap_d = cap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/scan_loader.sv
// Byte-to-scan-chain serialiser for the memory bank's scan port.
// Readback capture is built only when SCAN_LOADER_READBACK_EN is defined.
module scan_loader
  import scan_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  chain_scan_enable,
  output logic                  chain_scan_in,
  input  logic                  chain_scan_out,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = cnt_w(DATA_WIDTH);
  localparam int CW = cnt_w(MEM_SIZE + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(MEM_SIZE - 1);
  localparam logic [CW-1:0] BYTE_ONE  = CW'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CW-1:0]         byte_q, byte_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  last_bit_s, last_byte_s, kill_s, take_s;

  // in_ready and busy come only from registers so the host sees no input path.
  always_comb begin
    last_bit_s  = (state_q == SHIFT) && (bit_q == LAST_BIT);
    last_byte_s = (byte_q == LAST_BYTE);
    in_ready    = (state_q == LOAD) || (last_bit_s && !last_byte_s);
    busy        = (state_q == LOAD) || (state_q == SHIFT);
    kill_s      = abort && (state_q != IDLE);
    take_s      = in_valid && in_ready && !kill_s;
  end

  always_comb begin
    state_d = state_q;
    if (kill_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = LOAD;
          else       state_d = IDLE;
        end
        LOAD: begin
          if (take_s) state_d = SHIFT;
          else        state_d = LOAD;
        end
        SHIFT: begin
          if (!last_bit_s)     state_d = SHIFT;
          else if (take_s)     state_d = SHIFT;
          else if (last_byte_s) state_d = DONE;
          else                 state_d = LOAD;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The shift register empties itself after a byte, so scan_in idles at 0.
  always_comb begin
    sr_d   = sr_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    if (kill_s || (state_q == IDLE) || (state_q == DONE)) begin
      sr_d   = '0;
      bit_d  = '0;
      byte_d = '0;
    end else if (take_s) begin
      sr_d  = in_data;
      bit_d = '0;
      if (last_bit_s) byte_d = byte_q + BYTE_ONE;
      else            byte_d = byte_q;
    end else if (state_q == SHIFT) begin
      sr_d = sr_q << 1;
      if (last_bit_s) begin
        bit_d  = '0;
        byte_d = byte_q + BYTE_ONE;
      end else begin
        bit_d = bit_q + BIT_ONE;
      end
    end else begin
      sr_d = sr_q;
    end
  end

  always_comb begin
    en_d   = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign chain_scan_enable = en_q;
  assign chain_scan_in     = sr_q[DATA_WIDTH-1];
  assign done              = done_q;

`ifdef SCAN_LOADER_READBACK_EN
  scan_capture #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .clr        (kill_s),
    .sample_en  (en_q),
    .sample_bit (chain_scan_out),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data)
  );
`else
  logic unused_scan_out;
  assign unused_scan_out = chain_scan_out;
  assign rd_valid        = 1'b0;
  assign rd_data         = '0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Self-checking bench for scan_loader with a behavioural scan-chain bank.
`timescale 1ns/1ps
module tb_scan_loader;
  localparam int DW = 8;
  localparam int MS = 32;
  localparam int CL = DW * MS;
`ifdef SCAN_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, in_valid, in_ready;
  logic [DW-1:0] in_data, rd_data;
  logic chain_scan_enable, chain_scan_in, chain_scan_out, rd_valid, busy, done;

  always #5 clk = ~clk;

  scan_loader #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .chain_scan_enable(chain_scan_enable), .chain_scan_in(chain_scan_in),
    .chain_scan_out(chain_scan_out), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  // Bank: cell c occupies chain[c*DW +: DW]; bits enter at 0, leave at CL-1.
  logic [CL-1:0] chain, preload_val;
  logic preload_req;
  assign chain_scan_out = chain[CL-1];
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (chain_scan_enable) chain <= {chain[CL-2:0], chain_scan_in};
  end

  // Monitor: readback bytes and lengths of enable-low gaps inside a load.
  logic [DW-1:0] rd_log[$];
  int gap_log[$];
  int low_run = 0;
  bit seen_en = 1'b0;
  always @(negedge clk) begin
    if (rd_valid) rd_log.push_back(rd_data);
    if (chain_scan_enable) begin
      if (seen_en && low_run > 0) gap_log.push_back(low_run);
      low_run <= 0;
      seen_en <= 1'b1;
    end else if (!busy) begin
      low_run <= 0;
      seen_en <= 1'b0;
    end else if (seen_en) begin
      low_run <= low_run + 1;
    end else begin
      low_run <= 0;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DW-1:0] bytes_q[MS];
  int gaps[MS];
  logic [CL-1:0] ref_img;

  typedef struct {
    int mode;       // 0 address, 1 zeros, 2 random
    bit preload;    // fill bank with 0xA5 first
    int gap_byte; int gap_len;
    int ev_kind;    // 0 none, 1 abort, 2 start pulse, 3 rst
    int ev_at;      // enabled-cycle count at which the event fires
    int exp_lat; int exp_en; int exp_dones; int exp_gap; int exp_rd;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [CL-1:0] mk_stream();
    logic [CL-1:0] s;
    s = '0;
    for (int j = 0; j < MS; j++) s[CL-1-DW*j -: DW] = bytes_q[j];
    return s;
  endfunction

  task automatic run_load(input int ev_kind, input int ev_at,
                          output int lat, output int en_seen, output int dones);
    int j, skip, post;
    bit pv, pr, fired, ended;
    j = 0; skip = 0; post = 0; pv = 1'b0; pr = 1'b0; fired = 1'b0; ended = 1'b0;
    lat = -1; en_seen = 0; dones = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 600 && !ended; cyc++) begin
      if (pv && pr) begin j++; skip = 0; end
      else if (pr && !pv) skip++;
      if (chain_scan_enable) en_seen++;
      if (done) begin dones++; if (lat < 0) lat = cyc; end
      if (lat >= 0 || (fired && ev_kind != 2)) post++;
      if (post == 1 && fired && ev_kind == 1)
        chk("after_abort_idle", {28'd0, busy, chain_scan_enable, in_ready, done}, 0);
      if (post == 1 && fired && ev_kind == 3)
        chk("after_rst_outputs", {in_ready, chain_scan_enable, chain_scan_in,
                                  rd_valid, busy, done, rd_data}, 0);
      if (post >= 4) ended = 1'b1;
      abort = 1'b0; rst = 1'b0; start = 1'b0;
      if (!fired && ev_kind != 0 && chain_scan_enable && en_seen == ev_at) begin
        fired = 1'b1;
        if (ev_kind == 1) abort = 1'b1;
        else if (ev_kind == 2) start = 1'b1;
        else rst = 1'b1;
      end
      if (j < MS && skip >= gaps[j]) begin in_valid = 1'b1; in_data = bytes_q[j]; end
      else begin in_valid = 1'b0; in_data = DW'($urandom); end
      pv = in_valid; pr = in_ready;
      if (!ended) @(negedge clk);
    end
    abort = 1'b0; rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("load_terminated", int'(ended), 1);
  endtask

  task automatic check_load(input int ev_kind, input int ev_at, input int exp_lat,
                            input int exp_en, input int exp_dones, input int exp_gap,
                            input int exp_rd);
    logic [CL-1:0] old, stream;
    int r0, g0, lat, en_seen, dones, gmax, bad;
    old = ref_img; r0 = rd_log.size(); g0 = gap_log.size();
    run_load(ev_kind, ev_at, lat, en_seen, dones);
    chk("done_latency", lat, exp_lat);
    chk("enabled_cycles", en_seen, exp_en);
    chk("done_pulses", dones, exp_dones);
    gmax = 0;
    for (int k = g0; k < gap_log.size(); k++) if (gap_log[k] > gmax) gmax = gap_log[k];
    chk("enable_gap", gmax, exp_gap);
    stream = mk_stream();
    if (ev_kind == 1 || ev_kind == 3) ref_img = (old << ev_at) | (stream >> (CL - ev_at));
    else ref_img = stream;
    bad = 0;
    for (int c = 0; c < MS; c++) if (chain[c*DW +: DW] !== ref_img[c*DW +: DW]) bad++;
    chk("image_bad_cells", bad, 0);
    chk("rd_count", rd_log.size() - r0, exp_rd);
    bad = 0;
    for (int k = 0; k < exp_rd && r0 + k < rd_log.size(); k++)
      if (rd_log[r0+k] !== old[CL-1-DW*k -: DW]) bad++;
    chk("rd_bytes_bad", bad, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r32, r5, r9, sum, gmax;
    r32 = RB ? 32 : 0; r5 = RB ? 5 : 0; r9 = RB ? 9 : 0;
    vecs[0] = '{0, 1'b0, 0,  0, 0, 0,   258, 256, 1, 0, r32};
    vecs[1] = '{0, 1'b0, 11, 3, 0, 0,   261, 256, 1, 3, r32};
    vecs[2] = '{1, 1'b1, 0,  0, 0, 0,   258, 256, 1, 0, r32};
    vecs[3] = '{0, 1'b0, 0,  0, 1, 43,  -1,  43,  0, 0, r5};
    vecs[4] = '{0, 1'b0, 0,  0, 0, 0,   258, 256, 1, 0, r32};
    vecs[5] = '{2, 1'b0, 0,  0, 2, 100, 258, 256, 1, 0, r32};
    vecs[6] = '{2, 1'b0, 0,  0, 3, 77,  -1,  77,  0, 0, r9};
    vecs[7] = '{0, 1'b0, 0,  2, 0, 0,   260, 256, 1, 0, r32};
    vecs[8] = '{2, 1'b0, 31, 5, 0, 0,   263, 256, 1, 5, r32};

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    preload_req = 1'b1; preload_val = '0; ref_img = '0;
    repeat (3) @(negedge clk);
    preload_req = 1'b0;
    chk("reset_outputs", {in_ready, chain_scan_enable, chain_scan_in, rd_valid,
                          busy, done, rd_data}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {in_ready, chain_scan_enable, chain_scan_in, rd_valid,
                           busy, done, rd_data}, 0);
    end

    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < MS; j++) begin
        gaps[j] = 0;
        if (vecs[t].mode == 0) bytes_q[j] = DW'(MS - 1 - j);
        else if (vecs[t].mode == 1) bytes_q[j] = '0;
        else bytes_q[j] = DW'($urandom);
      end
      if (vecs[t].gap_len > 0) gaps[vecs[t].gap_byte] = vecs[t].gap_len;
      if (vecs[t].preload) begin
        preload_val = {MS{8'hA5}};
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        ref_img = {MS{8'hA5}};
      end
      check_load(vecs[t].ev_kind, vecs[t].ev_at, vecs[t].exp_lat, vecs[t].exp_en,
                 vecs[t].exp_dones, vecs[t].exp_gap, vecs[t].exp_rd);
    end

    for (int r = 0; r < 4; r++) begin
      sum = 0; gmax = 0;
      for (int j = 0; j < MS; j++) begin
        bytes_q[j] = DW'($urandom);
        gaps[j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
        sum += gaps[j];
        if (j > 0 && gaps[j] > gmax) gmax = gaps[j];
      end
      check_load(0, 0, CL + 2 + sum, CL, 1, gmax, r32);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/scan_loader.md
# scan_loader

Host-side scan-chain programmer sitting directly upstream of the memory bank's serial scan port. It accepts whole bytes over a valid/ready handshake, serialises them onto the bank's scan input with `scan_enable` asserted, and (optionally) reassembles the bits falling out of the chain into readback bytes. It lets the test host or boot logic load and dump the whole memory image without using the parallel address/data port.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bits per memory cell and per handshake byte
- `MEM_SIZE`, 32, cells in the chain; chain length `CHAIN_LEN = DATA_WIDTH*MEM_SIZE`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle pulse; begins a full-chain load
- `abort`  in  1  synchronous abandon of current load
- `in_valid`  in  1  host byte valid
- `in_data`  in  DATA_WIDTH  host byte, shifted MSB first
- `in_ready`  out  1  loader can take `in_data` this cycle
- `chain_scan_enable`  out  1  drives bank `scan_enable`
- `chain_scan_in`  out  1  drives bank `scan_in`
- `chain_scan_out`  in  1  from bank `scan_out`
- `rd_valid`  out  1  one-cycle pulse, readback byte valid
- `rd_data`  out  DATA_WIDTH  readback byte
- `busy`  out  1  high in LOAD/SHIFT
- `done`  out  1  one-cycle pulse after last bit shifted

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `start`=1 → LOAD. Otherwise hold. `start` ignored in every other state.
- LOAD: `in_ready`=1. On `in_valid && in_ready`, byte copied into shift register, bit counter cleared → SHIFT.
- SHIFT: each cycle `chain_scan_enable`=1, `chain_scan_in` = shift-register MSB, register shifts left. After `DATA_WIDTH` bits byte counter increments.
  - `in_ready`=1 also in the final bit cycle of a byte unless it is byte `MEM_SIZE-1`; a byte accepted then starts shifting next cycle with no gap.
  - Last bit of last byte → DONE. Last bit with no byte accepted → LOAD (`chain_scan_enable`=0, chain holds).
- DONE: `done`=1 for one cycle → IDLE.
- Exactly `CHAIN_LEN` scan-enabled cycles per completed load. First byte supplied ends in cell `MEM_SIZE-1`; host supplies bytes in descending address order.
- `abort` (any state but IDLE) → IDLE next cycle; counters cleared, no `done`, chain left partially shifted. `abort` beats simultaneous handshake.
- Readback: in every scan-enabled cycle `chain_scan_out` sampled into capture register, MSB first. After each `DATA_WIDTH` samples, `rd_valid` pulses with that byte; first byte is old content of cell `MEM_SIZE-1`. No backpressure on readback.
- Counters: bit `$clog2(DATA_WIDTH)` bits, byte `$clog2(MEM_SIZE+1)` bits; neither wraps inside a load.

## Timing
- Reset: state IDLE; `in_ready`, `chain_scan_enable`, `chain_scan_in`, `rd_valid`, `busy`, `done` = 0; `rd_data` = 0; counters 0.
- All outputs registered except `in_ready` and `busy` (decoded from state/counter registers, no input path).
- `start` at edge k → `in_ready`=1 from cycle k+1.
- Handshake at edge k → `chain_scan_enable`=1 cycles k+1…k+DATA_WIDTH carrying bits MSB…LSB.
- Readback byte: `rd_valid` high the cycle after its last sample edge.
- Best-case load: `CHAIN_LEN+2` cycles from `start` to `done`.
- `rst` overrides all; mid-load reset behaves as `abort` plus output clear.

## Configuration
- `SCAN_LOADER_READBACK_EN` defined: capture register, sample counter, `rd_valid`/`rd_data` logic present as above.
- Undefined: capture logic removed; `rd_valid` tied 0, `rd_data` tied 0, `chain_scan_out` unused. Load behaviour unchanged.

## Structure
- Shared package `scan_pkg`: state enum typedef (IDLE/LOAD/SHIFT/DONE), `CHAIN_LEN` and counter-width localparams derived from `DATA_WIDTH`/`MEM_SIZE`.
- One sub-module: `scan_capture` (deserialiser + `rd_valid` generation), instantiated only under `SCAN_LOADER_READBACK_EN`.

## Test plan
- Reset then idle 10 cycles → all outputs 0, `in_ready`=0, `start` absent keeps IDLE.
- `start`, stream bytes 31…0 with value = address, `in_valid` held high → 256 contiguous enabled cycles, `done` at cycle 258, bank cell i reads i.
- Same load with `in_valid` dropped 3 cycles after byte 10 → `chain_scan_enable` low exactly 3 cycles, final image identical.
- Preload bank with 0xA5 everywhere, load 0x00s (readback on) → 32 `rd_valid` pulses each `rd_data`=0xA5.
- `abort` after 5 bytes + 3 bits → IDLE next cycle, no `done`, new `start` loads full image correctly.
- `start` asserted during SHIFT and `rst` pulsed mid-byte → `start` ignored; after `rst` all outputs 0 and counters 0.
